optimum_setpoint_controller: RTL



---
 rtl/optset_pkg.sv | 64 ++++++
 rtl/optimum_setpoint_controller_if.sv | 22 ++
 rtl/optset_zone.sv | 117 +++++++++++
 rtl/optimum_setpoint_controller.sv | 37 +++
 4 files changed

// File: rtl/optset_pkg.sv
// Shared types, band thresholds/targets and BCD helpers for the optimum setpoint controller.
package optset_pkg;

   typedef enum logic [2:0] {
      BAND_OFF,
      BAND_LOW,
      BAND_MED,
      BAND_HIGH,
      BAND_FULL
   } band_t;

   localparam logic [6:0] LB_LOW  = 7'd1;
   localparam logic [6:0] LB_MED  = 7'd15;
   localparam logic [6:0] LB_HIGH = 7'd25;
   localparam logic [6:0] LB_FULL = 7'd35;

   localparam logic [4:0] TGT_OFF  = 5'd0;
   localparam logic [4:0] TGT_LOW  = 5'd26;
   localparam logic [4:0] TGT_MED  = 5'd24;
   localparam logic [4:0] TGT_HIGH = 5'd22;
   localparam logic [4:0] TGT_FULL = 5'd20;

   function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
      return 7'(tens) * 7'd10 + 7'(ones);
   endfunction

   // Only ever called with values 0..26, so two tens comparisons suffice.
   function automatic logic [7:0] bin_to_bcd(input logic [4:0] v);
      logic [3:0] t;
      logic [3:0] o;
      t = (v >= 5'd30) ? 4'd3 : (v >= 5'd20) ? 4'd2 : (v >= 5'd10) ? 4'd1 : 4'd0;
      o = 4'(v - 5'(t) * 5'd10);
      return {t, o};
   endfunction

   function automatic band_t band_of(input logic [6:0] count);
      if (count < LB_LOW)       return BAND_OFF;
      else if (count < LB_MED)  return BAND_LOW;
      else if (count < LB_HIGH) return BAND_MED;
      else if (count < LB_FULL) return BAND_HIGH;
      else                      return BAND_FULL;
   endfunction

   function automatic logic [6:0] lower_bound(input band_t b);
      case (b)
         BAND_LOW:  return LB_LOW;
         BAND_MED:  return LB_MED;
         BAND_HIGH: return LB_HIGH;
         BAND_FULL: return LB_FULL;
         default:   return 7'd0;
      endcase
   endfunction

   function automatic logic [4:0] target_of(input band_t b);
      case (b)
         BAND_LOW:  return TGT_LOW;
         BAND_MED:  return TGT_MED;
         BAND_HIGH: return TGT_HIGH;
         BAND_FULL: return TGT_FULL;
         default:   return TGT_OFF;
      endcase
   endfunction

endpackage

// File: rtl/optimum_setpoint_controller_if.sv
// Per-zone count inputs, shared selector and setpoint display outputs of the controller.
interface optimum_setpoint_controller_if #(parameter int NUM_ZONES = 2);

   logic [7:0]             Selector;
   logic [4*NUM_ZONES-1:0] PersonTens;
   logic [4*NUM_ZONES-1:0] PersonOnes;
   logic [4*NUM_ZONES-1:0] TempTens;
   logic [4*NUM_ZONES-1:0] TempOnes;
   logic [NUM_ZONES-1:0]   Settled;
   logic [NUM_ZONES-1:0]   BcdError;

   modport master (
      output Selector, PersonTens, PersonOnes,
      input  TempTens, TempOnes, Settled, BcdError
   );

   modport slave (
      input  Selector, PersonTens, PersonOnes,
      output TempTens, TempOnes, Settled, BcdError
   );

endinterface

// File: rtl/optset_zone.sv
// One zone: count debounce, occupancy band FSM and setpoint ramp.
// OPTSET_HYSTERESIS_EN adds hysteresis to downward band moves.
module optset_zone
   import optset_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int RAMP_CYCLES   = 8,
   parameter int HYST          = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_en,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [3:0] temp_tens,
   output logic [3:0] temp_ones,
   output logic       settled,
   output logic       bcd_error
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

   if (STABLE_CYCLES < 1 || RAMP_CYCLES < 1 || HYST < 0) begin : g_bad_param
      $error("optset_zone: illegal parameter value");
   end

   logic [6:0]    cand;
   logic [6:0]    committed;
   logic [SW-1:0] stab_cnt;
   logic [SW-1:0] stab_next;
   band_t         band;
   band_t         band_next;
   logic [4:0]    cur;
   logic [4:0]    target;
   logic [RW-1:0] ramp_cnt;
   logic          digits_ok;
   logic [6:0]    sample;

   assign digits_ok = (tens <= 4'd9) && (ones <= 4'd9);
   assign sample    = bcd_to_bin(tens, ones);
   assign target    = target_of(band);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      stab_next = stab_cnt;
      if (sample != cand)
         stab_next = SW'(1);
      else if (stab_cnt != SW'(STABLE_CYCLES))
         stab_next = stab_cnt + SW'(1);
   end

`ifdef OPTSET_HYSTERESIS_EN
   band_t raw_band;

   // Upward moves are immediate; downward ones need the count to drop HYST below the band floor.
   always_comb begin
      raw_band  = band_of(committed);
      band_next = band;
      if (committed == 7'd0)
         band_next = BAND_OFF;
      else if (raw_band > band)
         band_next = raw_band;
      else if (raw_band < band && int'(committed) < int'(lower_bound(band)) - HYST)
         band_next = raw_band;
   end
`else
   always_comb begin
      band_next = band_of(committed);
   end
`endif

   // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand      <= '0;
         committed <= '0;
         stab_cnt  <= '0;
         band      <= BAND_OFF;
         cur       <= '0;
         ramp_cnt  <= '0;
         bcd_error <= 1'b0;
      end else begin
         bcd_error <= sample_en && !digits_ok;
         if (sample_en && digits_ok) begin
            cand     <= sample;
            stab_cnt <= stab_next;
            if (stab_next == SW'(STABLE_CYCLES))
               committed <= sample;
         end

         band <= band_next;

         // A step on the same edge as a band change still moves toward the old target.
         if (target == 5'd0) begin
            cur      <= '0;
            ramp_cnt <= '0;
         end else if (cur == 5'd0) begin
            cur      <= target;
            ramp_cnt <= '0;
         end else if (cur == target) begin
            ramp_cnt <= '0;
         end else if (ramp_cnt == RW'(RAMP_CYCLES - 1)) begin
            cur      <= (cur > target) ? cur - 5'd1 : cur + 5'd1;
            ramp_cnt <= '0;
         end else if (band_next != band) begin
            ramp_cnt <= '0;
         end else begin
            ramp_cnt <= ramp_cnt + RW'(1);
         end
      end
   end

   assign {temp_tens, temp_ones} = bin_to_bcd(cur);
   assign settled = (cur == target) && (cand == committed);

endmodule

// File: rtl/optimum_setpoint_controller.sv
// Multi-zone occupancy-to-setpoint controller; one optset_zone per room, shared selector decode.
// Build option: OPTSET_HYSTERESIS_EN enables band hysteresis in every zone.
module optimum_setpoint_controller #(
   parameter int NUM_ZONES     = 2,
   parameter int SEL_CODE      = 3,
   parameter int STABLE_CYCLES = 4,
   parameter int RAMP_CYCLES   = 8,
   parameter int HYST          = 2
) (
   input logic Clock,
   input logic Reset_n,
   optimum_setpoint_controller_if.slave bus
);

   logic sample_en;

   assign sample_en = (bus.Selector == 8'(SEL_CODE));

   for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
      optset_zone #(
         .STABLE_CYCLES(STABLE_CYCLES),
         .RAMP_CYCLES  (RAMP_CYCLES),
         .HYST         (HYST)
      ) u_zone (
         .clk      (Clock),
         .rst_n    (Reset_n),
         .sample_en(sample_en),
         .tens     (bus.PersonTens[4*z +: 4]),
         .ones     (bus.PersonOnes[4*z +: 4]),
         .temp_tens(bus.TempTens[4*z +: 4]),
         .temp_ones(bus.TempOnes[4*z +: 4]),
         .settled  (bus.Settled[z]),
         .bcd_error(bus.BcdError[z])
      );
   end

endmodule
